// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared opcodes, instruction field positions and encoder FSM states
//
// Purpose: single source of truth for the instruction format. The control
// decoder and the instruction encoder both import this package so that the
// opcode values and field positions cannot drift apart.
// Contents:
//   OP_R, OP_ADDI, OP_SW, OP_LW  supported 5-bit opcodes
//   *_LSB, *_W                   instruction field positions and widths
//   enc_state_e                  encoder FSM states (IDLE, PEND, FULL)
//   is_legal_op()                true for the opcodes listed above

package isa_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    localparam int FIELD_W   = 5;
    localparam int IMM_W     = 17;
    localparam int OP_LSB    = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational field-to-word instruction packer
//
// Purpose: builds the 32-bit instruction word from decoded fields and flags
// whether the opcode is one the control decoder understands.
// Ports:
//   opcode_i        5   opcode
//   rd_i/rs_i/rt_i  5   register numbers
//   shamt_i         5   shift amount (R-type only)
//   aluop_i         5   ALU op (R-type only)
//   imm_i           17  immediate (I-type only)
//   word_o          32  encoded word (0 when illegal)
//   legal_o         1   opcode is supported

module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       shamt_i,
    input  logic [4:0]       aluop_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic [31:0]      word_o,
    output logic             legal_o
);

    always_comb begin
        word_o  = 32'h0;
        legal_o = is_legal_op(opcode_i);
        if (legal_o) begin
            word_o[OP_LSB +: FIELD_W] = opcode_i;
            word_o[RD_LSB +: FIELD_W] = rd_i;
            word_o[RS_LSB +: FIELD_W] = rs_i;
            if (opcode_i == OP_R) begin
                // bits [1:0] stay zero in the R format
                word_o[RT_LSB    +: FIELD_W] = rt_i;
                word_o[SHAMT_LSB +: FIELD_W] = shamt_i;
                word_o[ALUOP_LSB +: FIELD_W] = aluop_i;
            end else begin
                // I format: rt, shamt and aluop are ignored
                word_o[IMM_LSB +: IMM_W] = imm_i;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams packed instruction words into instruction memory
//
// Purpose: accepts decoded field bundles (valid/ready), packs them into 32-bit
// words and writes them to consecutive instruction-memory addresses through a
// single registered output stage. Illegal opcodes are accepted and dropped.
// Ports:
//   clock, reset (sync, active-low), clear (sync)
//   in_valid/in_ready, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm
//   imem_we, imem_ready, imem_addr [ADDR_W], imem_data [32]
//   full, err_illegal, illegal_cnt [8], word_cnt [ADDR_W+1]

module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              full,
    output logic              err_illegal,
    output logic [7:0]        illegal_cnt,
    output logic [ADDR_W:0]   word_cnt
);

    // word_cnt value while the final word (number DEPTH) is pending
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [7:0]        ill_q, ill_d;

    logic [31:0] packed_word;
    logic        packed_legal;
    logic        last_pend;
    logic        accept;
    logic        legal_acc;
    logic        illegal_acc;
    logic        commit;

    instr_pack u_pack (
        .opcode_i (in_opcode),
        .rd_i     (in_rd),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .shamt_i  (in_shamt),
        .aluop_i  (in_aluop),
        .imm_i    (in_imm),
        .word_o   (packed_word),
        .legal_o  (packed_legal)
    );

    assign last_pend = (cnt_q == LAST_CNT);

    // Pass-through in PEND only when the pending word leaves this cycle and
    // there is still room for another one behind it.
    assign in_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_PEND) && imem_ready && !last_pend);

    assign accept      = in_valid && in_ready;
    assign legal_acc   = accept && packed_legal;
    assign illegal_acc = accept && !packed_legal;
    assign commit      = (state_q == ST_PEND) && imem_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ill_d   = ill_q;

        if (commit) begin
            cnt_d = cnt_q + (ADDR_W+1)'(1);
            // The final commit leaves the address on the last word so it
            // never wraps past DEPTH-1 while sitting in FULL.
            if (!last_pend) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (legal_acc) begin
                    state_d = ST_PEND;
                    data_d  = packed_word;
                end
            end
            ST_PEND: begin
                // a legal accept here implies a commit in the same cycle
                if (legal_acc) begin
                    data_d = packed_word;
                end else if (commit) begin
                    state_d = last_pend ? ST_FULL : ST_IDLE;
                end
            end
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (illegal_acc) begin
            err_d = 1'b1;
            if (ill_q != 8'hFF) begin
                ill_d = ill_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ill_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ill_q   <= ill_d;
        end
    end

    // decoded directly from registered state, so no in_* to imem_* path
    assign imem_we     = (state_q == ST_PEND);
    assign full        = (state_q == ST_FULL);
    assign imem_addr   = addr_q;
    assign imem_data   = data_q;
    assign err_illegal = err_q;
    assign illegal_cnt = ill_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder

module tb_instr_encoder;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_opcode = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_shamt = '0;
    logic [4:0]        in_aluop = '0;
    logic [16:0]       in_imm = '0;
    logic              imem_we;
    logic              imem_ready = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              full;
    logic              err_illegal;
    logic [7:0]        illegal_cnt;
    logic [ADDR_W:0]   word_cnt;

    int n_pass  = 0;
    int n_total = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_shamt    (in_shamt),
        .in_aluop    (in_aluop),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_ready  (imem_ready),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .full        (full),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt),
        .word_cnt    (word_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [16:0] imm;
        logic [31:0] exp_word;
        logic        exp_legal;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] al,
                         input logic [16:0] imm);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_shamt  = sh;
        in_aluop  = al;
        in_imm    = imm;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'b00101, 5'd1,  5'd0,  5'd0,  5'd0,  5'd0,  17'd5,       32'h28400005, 1'b1};
        vecs[1] = '{5'b00000, 5'd3,  5'd1,  5'd2,  5'd0,  5'd0,  17'd0,       32'h00C22000, 1'b1};
        vecs[2] = '{5'b01000, 5'd4,  5'd2,  5'd0,  5'd0,  5'd0,  17'd8,       32'h41040008, 1'b1};
        vecs[3] = '{5'b00111, 5'd2,  5'd3,  5'd0,  5'd0,  5'd0,  17'h1FFFF,   32'h3887FFFF, 1'b1};
        vecs[4] = '{5'b00000, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF,   32'h07FFFFFC, 1'b1};
        vecs[5] = '{5'b00101, 5'd1,  5'd0,  5'd31, 5'd31, 5'd31, 17'd5,       32'h28400005, 1'b1};
        vecs[6] = '{5'b00001, 5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  17'd1,       32'h00000000, 1'b0};
        vecs[7] = '{5'b11111, 5'd7,  5'd7,  5'd7,  5'd7,  5'd7,  17'd7,       32'h00000000, 1'b0};

        // reset state
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_data", imem_data, 0);
        check("rst_full", full, 0);
        check("rst_err", err_illegal, 0);
        check("rst_illcnt", illegal_cnt, 0);
        check("rst_wcnt", word_cnt, 0);
        check("rst_ready", in_ready, 1);

        // packing table
        imem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_clear();
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].shamt,
                  vecs[i].aluop, vecs[i].imm);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_we", i), imem_we, vecs[i].exp_legal);
            check($sformatf("vec%0d_err", i), err_illegal, !vecs[i].exp_legal);
            if (vecs[i].exp_legal) begin
                check($sformatf("vec%0d_data", i), imem_data, vecs[i].exp_word);
                check($sformatf("vec%0d_addr", i), imem_addr, 0);
            end
        end

        // single addi, commit after one cycle
        do_clear();
        drive(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5);
        tick();
        in_valid = 1'b0;
        check("t1_we", imem_we, 1);
        check("t1_data", imem_data, 32'h28400005);
        check("t1_addr", imem_addr, 0);
        tick();
        check("t1_wcnt", word_cnt, 1);
        check("t1_we_off", imem_we, 0);
        check("t1_addr_next", imem_addr, 1);

        // back-to-back R then lw
        do_clear();
        drive(5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0);
        tick();
        check("t2_ready_pass", in_ready, 1);
        check("t2_data0", imem_data, 32'h00C22000);
        check("t2_addr0", imem_addr, 0);
        drive(5'b01000, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0, 17'd8);
        tick();
        in_valid = 1'b0;
        check("t2_we1", imem_we, 1);
        check("t2_data1", imem_data, 32'h41040008);
        check("t2_addr1", imem_addr, 1);
        tick();
        check("t2_wcnt", word_cnt, 2);
        check("t2_we_off", imem_we, 0);

        // illegal between two legal bundles
        do_clear();
        drive(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5);
        tick();
        check("t3_addr0", imem_addr, 0);
        drive(5'b00001, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 17'd2);
        tick();
        check("t3_err", err_illegal, 1);
        check("t3_illcnt", illegal_cnt, 1);
        check("t3_we_drop", imem_we, 0);
        check("t3_wcnt1", word_cnt, 1);
        drive(5'b01000, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0, 17'd8);
        tick();
        in_valid = 1'b0;
        check("t3_data1", imem_data, 32'h41040008);
        check("t3_addr1", imem_addr, 1);
        tick();
        check("t3_wcnt2", word_cnt, 2);

        // stall with sw pending
        do_clear();
        imem_ready = 1'b0;
        drive(5'b00111, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 17'h1FFFF);
        tick();
        drive(5'b00101, 5'd9, 5'd9, 5'd0, 5'd0, 5'd0, 17'd9);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t4_ready_c%0d", c), in_ready, 0);
            check($sformatf("t4_we_c%0d", c), imem_we, 1);
            check($sformatf("t4_data_c%0d", c), imem_data, 32'h3887FFFF);
            check($sformatf("t4_addr_c%0d", c), imem_addr, 0);
            tick();
        end
        in_valid   = 1'b0;
        imem_ready = 1'b1;
        tick();
        check("t4_wcnt", word_cnt, 1);
        check("t4_we_off", imem_we, 0);
        check("t4_addr", imem_addr, 1);

        // fill to DEPTH with a continuous stream
        do_clear();
        imem_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            drive(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'(w + 16));
            tick();
            check($sformatf("t5_data%0d", w), imem_data, 32'h28400010 + 32'(w));
            check($sformatf("t5_addr%0d", w), imem_addr, 32'(w));
        end
        check("t5_ready_last", in_ready, 0);
        drive(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd99);
        tick();
        check("t5_full", full, 1);
        check("t5_ready_full", in_ready, 0);
        check("t5_we_full", imem_we, 0);
        check("t5_wcnt", word_cnt, 4);
        tick();
        tick();
        check("t5_wcnt_hold", word_cnt, 4);
        check("t5_full_hold", full, 1);
        in_valid = 1'b0;
        do_clear();
        check("t5_clr_addr", imem_addr, 0);
        check("t5_clr_full", full, 0);
        check("t5_clr_wcnt", word_cnt, 0);

        // clear abandons a stalled pending word
        imem_ready = 1'b0;
        drive(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5);
        tick();
        in_valid = 1'b0;
        check("t6_we_pend", imem_we, 1);
        do_clear();
        check("t6_we", imem_we, 0);
        check("t6_wcnt", word_cnt, 0);
        check("t6_addr", imem_addr, 0);
        imem_ready = 1'b1;
        tick();
        check("t6_we_after", imem_we, 0);
        check("t6_wcnt_after", word_cnt, 0);

        // illegal counter saturation
        do_clear();
        drive(5'b00010, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0);
        for (int k = 0; k < 260; k++) tick();
        in_valid = 1'b0;
        check("sat_illcnt", illegal_cnt, 255);
        check("sat_err", err_illegal, 1);
        check("sat_wcnt", word_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
